uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
UART transmit engine, the serializer counterpart of the UART receiver on the APB UART datapath. It accepts one character per valid/ready handshake from the TX FIFO or register side. It serializes the character onto tx_o as start bit, 5–8 data bits LSB first, optional parity, and 1 or 2 stop bits. Bit timing is derived from the shared baud tick_i, OVERSAMPLE ticks per bit, matching the receiver framing.

Parameters:
OVERSAMPLE, 16, tick_i pulses per bit period (power of two, >= 2)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
tx_en_i  input  1  transmitter enable; 0 blocks new frames
tick_i  input  1  one-cycle baud oversample strobe
data_bit_num_i  input  2  00=5, 01=6, 10=7, 11=8 data bits
parity_en_i  input  1  1 = parity bit appended
parity_type_i  input  1  1 = even, 0 = odd
stop_bit_num_i  input  1  0 = 1 stop bit, 1 = 2 stop bits
cts_ni  input  1  clear-to-send, active low; 1 holds new frames
data_i  input  8  character; unused upper bits ignored
data_valid_i  input  1  character valid
ready_o  output  1  block can accept a character this cycle
tx_o  output  1  serial line, idle high
tx_done_o  output  1  one-cycle pulse at end of last stop bit
busy_o  output  1  frame in progress

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n. Reset values: tx_o=1, ready_o=0 while reset_n=0 and 1 from the first clk after release, tx_done_o=0, busy_o=0. State=IDLE, all counters 0.
- ready_o = (state==IDLE) & tx_en_i & ~cts_ni. This is combinational from registered state plus inputs.
- Accept happens when data_valid_i & ready_o at a clk edge. On accept, register data_i, data_bit_num_i, parity_en_i, parity_type_i and stop_bit_num_i. Config changes mid-frame have no effect.
- On accept: state becomes START, tx_o=0 from the next cycle, busy_o=1, and the tick counter is cleared to 0.
- Bit timing: the tick counter increments on tick_i. A bit ends on (cnt==OVERSAMPLE-1) & tick_i, and cnt then wraps to 0. Each bit lasts exactly OVERSAMPLE ticks.
- Parity bit = ~(^data_masked ^ parity_type). Even parity makes the total count of ones (data + parity) even. This is the inverse of the receiver check.
- FSM transitions, all taken at bit end:
  - IDLE: go to START on accept.
  - START (tx_o=0): go to DATA with bit index 0.
  - DATA (tx_o=shift[0], LSB first): shift right. When the index reaches data_size-1, go to PARITY if parity enabled, otherwise STOP.
  - PARITY (tx_o=parity): go to STOP.
  - STOP (tx_o=1): with 2 stop bits, remain for a second period. At the end of the last stop period, go to IDLE and pulse tx_done_o.
- Frame length in bits = 1 + data_size + parity_en + stop_size. 8N1 = 10 bits = 160 ticks.
- Back-to-back: ready_o can rise the cycle after tx_done_o. There is no gap beyond one clk cycle between frames.
- tx_en_i or cts_ni changing mid-frame: the current frame always completes. These inputs gate only the next accept.
- tick_i without an active frame: the counter holds 0 in IDLE.
- Reset mid-frame: the line returns to 1 immediately and the character is lost.

Decomposition:
- uart_pkg holds:
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP}
  - data-bit encoding constants DBITS_5..DBITS_8
  - a function data_size(data_bit_num) returning 4-bit 5..8
  - OVERSAMPLE_DEFAULT=16
- One sub-module, tx_shift_register: an 8-bit PISO with load_en, shift_en, data_i[7:0] and serial_o (LSB). It mirrors the receiver shift_register.

Test Plan:
- 8N1, data_i=0xA5, accept, tick_i every cycle: tx_o is 0 for 16 ticks, then 1,0,1,0,0,1,0,1 each for 16 ticks, then 1 for 16 ticks. tx_done_o pulses at tick 160 and ready_o returns to 1.
- 7E1 then 7O1 with data_i=0xD3 (low 7 bits have 4 ones): parity bit is 0 for even and 1 for odd. Frame = 10 bits, and data_i[7] is never driven.
- 5N2 with data_i=0x1F and tick_i every 3rd cycle: 1 start + 5 ones + 2 stop = 8 bits = 128 ticks = 384 clks. tx_done_o asserts exactly once.
- cts_ni=1 with data_valid_i=1: ready_o=0 and tx_o stays 1. Drop cts_ni to 0, and the start bit appears the next cycle. Raise cts_ni mid-frame, and the frame completes.
- Two back-to-back frames 0x00 then 0xFF with data_valid_i held: the second start bit follows the first stop bit with at most one clk gap. Parameter/config changes during frame 1 do not alter frame 1.
- Assert reset_n=0 during DATA bit 3: tx_o=1 and busy_o=0 asynchronously. After release, a new 0x55 frame transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART framing types, data-width encodings and helpers.
// Pure declarations: no latency, no flow control.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  localparam int OVERSAMPLE_DEFAULT = 16;

  function automatic logic [3:0] data_size(input logic [1:0] data_bit_num);
    return 4'd5 + {2'b00, data_bit_num};
  endfunction

  // Keeps only the data bits that actually go on the line.
  function automatic logic [7:0] data_mask(input logic [1:0] data_bit_num);
    return 8'hFF >> (2'd3 - data_bit_num);
  endfunction

endpackage

// File: rtl/tx_shift_register.sv
// 8-bit parallel-in serial-out register, LSB presented on serial_o.
// Load/shift take effect on the next clk edge; no backpressure (load wins over shift).
module tx_shift_register (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_en,
  input  logic       shift_en,
  input  logic [7:0] data_i,
  output logic       serial_o
);

  logic [7:0] shift_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
    end else if (load_en) begin
      shift_q <= data_i;
    end else if (shift_en) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

  assign serial_o = shift_q[0];

endmodule

// File: rtl/uart_transmitter.sv
// UART serializer: start, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// tx_o starts the cycle after accept; ready_o is low for the whole frame and while cts_ni=1 or tx_en_i=0.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_en_i,
  input  logic       tick_i,
  input  logic [1:0] data_bit_num_i,
  input  logic       parity_en_i,
  input  logic       parity_type_i,
  input  logic       stop_bit_num_i,
  input  logic       cts_ni,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       tx_done_o,
  output logic       busy_o
);

  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(OVERSAMPLE - 1);

  tx_state_t   state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic        stop_idx_q;
  logic [1:0]  dbn_q;
  logic        par_en_q;
  logic        stop2_q;
  logic        par_q;
  logic        rdy_en_q;

  logic        accept;
  logic        bit_end;
  logic        last_data_bit;
  logic        parity_next;
  logic        shift_en;
  logic        serial;

  assign ready_o       = rdy_en_q & (state_q == IDLE) & tx_en_i & ~cts_ni;
  assign accept        = data_valid_i & ready_o;
  assign bit_end       = tick_i & (cnt_q == CNT_MAX);
  assign last_data_bit = ({1'b0, bit_idx_q} == data_size(dbn_q) - 4'd1);
  assign parity_next   = ~(^(data_i & data_mask(data_bit_num_i)) ^ parity_type_i);

  // The register runs one bit ahead so tx_o can be loaded from serial at each bit end.
  assign shift_en = bit_end & ((state_q == START) | ((state_q == DATA) & ~last_data_bit));

  tx_shift_register u_shift (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_en  (accept),
    .shift_en (shift_en),
    .data_i   (data_i),
    .serial_o (serial)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      dbn_q      <= '0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      par_q      <= 1'b0;
      rdy_en_q   <= 1'b0;
      tx_o       <= 1'b1;
      tx_done_o  <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      rdy_en_q  <= 1'b1;
      tx_done_o <= 1'b0;
      if (state_q == IDLE) begin
        cnt_q <= '0;
        if (accept) begin
          dbn_q      <= data_bit_num_i;
          par_en_q   <= parity_en_i;
          stop2_q    <= stop_bit_num_i;
          par_q      <= parity_next;
          bit_idx_q  <= '0;
          stop_idx_q <= 1'b0;
          state_q    <= START;
          tx_o       <= 1'b0;
          busy_o     <= 1'b1;
        end
      end else begin
        if (tick_i) begin
          cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
        end
        if (bit_end) begin
          case (state_q)
            START: begin
              state_q   <= DATA;
              bit_idx_q <= '0;
              tx_o      <= serial;
            end
            DATA: begin
              if (last_data_bit) begin
                state_q <= par_en_q ? PARITY : STOP;
                tx_o    <= par_en_q ? par_q : 1'b1;
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
                tx_o      <= serial;
              end
            end
            PARITY: begin
              state_q <= STOP;
              tx_o    <= 1'b1;
            end
            STOP: begin
              if (stop2_q && !stop_idx_q) begin
                stop_idx_q <= 1'b1;
              end else begin
                state_q   <= IDLE;
                busy_o    <= 1'b0;
                tx_done_o <= 1'b1;
                tx_o      <= 1'b1;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: frame shapes, parity, flow gating, back-to-back and reset.
module tb_uart_transmitter;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tx_en_i;
  logic       tick_i;
  logic [1:0] data_bit_num_i;
  logic       parity_en_i;
  logic       parity_type_i;
  logic       stop_bit_num_i;
  logic       cts_ni;
  logic [7:0] data_i;
  logic       data_valid_i;
  logic       ready_o;
  logic       tx_o;
  logic       tx_done_o;
  logic       busy_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int tick_cnt = 0;
  int tick_div = 1;
  int ph = 0;
  int last_done_cyc = -100;

  uart_transmitter #(.OVERSAMPLE(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .tx_en_i        (tx_en_i),
    .tick_i         (tick_i),
    .data_bit_num_i (data_bit_num_i),
    .parity_en_i    (parity_en_i),
    .parity_type_i  (parity_type_i),
    .stop_bit_num_i (stop_bit_num_i),
    .cts_ni         (cts_ni),
    .data_i         (data_i),
    .data_valid_i   (data_valid_i),
    .ready_o        (ready_o),
    .tx_o           (tx_o),
    .tx_done_o      (tx_done_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; counts the tick applied at the edge, then drives the next tick_i.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (tick_i) tick_cnt++;
    #1;
    ph = (ph + 1) % tick_div;
    tick_i = (ph == 0);
  endtask

  // mode: 0 plain, 1 hold valid and disturb config mid-frame, 2 check back-to-back gap,
  // 3 raise cts_ni mid-frame. exp[k] is the k-th bit on the line (k=0 is the start bit).
  task automatic send_frame(input string tag, input logic [7:0] d, input logic [1:0] dbn,
                            input logic pe, input logic pt, input logic sb,
                            input logic [11:0] exp, input int nbits, input int mode);
    int wait_cyc;
    int tc;
    int base;
    logic [11:0] checked;
    bit done;
    wait_cyc = 0;
    tc = 0;
    checked = '0;
    done = 1'b0;
    data_i = d;
    data_bit_num_i = dbn;
    parity_en_i = pe;
    parity_type_i = pt;
    stop_bit_num_i = sb;
    data_valid_i = 1'b1;
    while (!ready_o && wait_cyc < 200) begin
      step();
      wait_cyc++;
    end
    check({tag, "_ready"}, ready_o, 1);
    step();
    if (mode == 2) check({tag, "_gap"}, (cyc - last_done_cyc) <= 1, 1);
    check({tag, "_start_tx"}, tx_o, 0);
    check({tag, "_start_busy"}, busy_o, 1);
    if (mode != 1) data_valid_i = 1'b0;
    if (mode == 1) begin
      data_i = ~d;
      parity_en_i = 1'b1;
      data_bit_num_i = DBITS_5;
      stop_bit_num_i = 1'b1;
      parity_type_i = ~pt;
    end
    base = tick_cnt;
    for (int i = 0; i < 16 * 12 * 4 && !done; i++) begin
      step();
      tc = tick_cnt - base;
      if (mode == 1 && tc >= 64) begin
        data_bit_num_i = dbn;
        parity_en_i = pe;
        parity_type_i = pt;
        stop_bit_num_i = sb;
      end
      if (mode == 3 && tc == 40) cts_ni = 1'b1;
      if (tx_done_o) begin
        done = 1'b1;
      end else if (tc % 16 == 8 && tc / 16 < nbits && !checked[tc/16]) begin
        checked[tc/16] = 1'b1;
        check($sformatf("%s_bit%0d", tag, tc / 16), tx_o, exp[tc/16]);
      end
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_len_ticks"}, tc, 16 * nbits);
    check({tag, "_end_tx"}, tx_o, 1);
    check({tag, "_end_busy"}, busy_o, 0);
    last_done_cyc = cyc;
    if (mode != 1) begin
      step();
      check({tag, "_done_pulse"}, tx_done_o, 0);
      check({tag, "_ready_after"}, ready_o, (mode == 3) ? 0 : 1);
    end
  endtask

  initial begin
    int base;
    int guard;
    reset_n = 1'b1;
    tx_en_i = 1'b1;
    tick_i = 1'b1;
    cts_ni = 1'b0;
    data_i = 8'h00;
    data_valid_i = 1'b0;
    data_bit_num_i = DBITS_8;
    parity_en_i = 1'b0;
    parity_type_i = 1'b0;
    stop_bit_num_i = 1'b0;
    #2 reset_n = 1'b0;
    #20;
    check("rst_tx", tx_o, 1);
    check("rst_ready", ready_o, 0);
    check("rst_done", tx_done_o, 0);
    check("rst_busy", busy_o, 0);
    reset_n = 1'b1;
    step();
    check("post_rst_ready", ready_o, 1);

    for (int i = 0; i < 5; i++) step();
    check("idle_tick_busy", busy_o, 0);
    check("idle_tick_tx", tx_o, 1);

    tx_en_i = 1'b0;
    data_valid_i = 1'b1;
    step();
    check("txen_off_ready", ready_o, 0);
    check("txen_off_busy", busy_o, 0);
    tx_en_i = 1'b1;
    data_valid_i = 1'b0;

    send_frame("f8n1_a5", 8'hA5, DBITS_8, 1'b0, 1'b0, 1'b0, 12'b0011_0100_1010, 10, 0);
    send_frame("f7e1_d3", 8'hD3, DBITS_7, 1'b1, 1'b1, 1'b0, 12'b0010_1010_0110, 10, 0);
    send_frame("f7o1_d3", 8'hD3, DBITS_7, 1'b1, 1'b0, 1'b0, 12'b0011_1010_0110, 10, 0);

    tick_div = 3;
    ph = 0;
    send_frame("f5n2_1f", 8'h1F, DBITS_5, 1'b0, 1'b0, 1'b1, 12'b0000_1111_1110, 8, 0);
    tick_div = 1;
    ph = 0;
    tick_i = 1'b1;

    cts_ni = 1'b1;
    data_i = 8'hA5;
    data_bit_num_i = DBITS_8;
    parity_en_i = 1'b0;
    stop_bit_num_i = 1'b0;
    data_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("cts_hold_ready", ready_o, 0);
    check("cts_hold_tx", tx_o, 1);
    check("cts_hold_busy", busy_o, 0);
    cts_ni = 1'b0;
    #1;
    check("cts_drop_ready", ready_o, 1);
    send_frame("fcts_a5", 8'hA5, DBITS_8, 1'b0, 1'b0, 1'b0, 12'b0011_0100_1010, 10, 3);
    cts_ni = 1'b0;

    send_frame("b2b_00", 8'h00, DBITS_8, 1'b0, 1'b0, 1'b0, 12'b0010_0000_0000, 10, 1);
    send_frame("b2b_ff", 8'hFF, DBITS_8, 1'b0, 1'b0, 1'b0, 12'b0011_1111_1110, 10, 2);

    data_i = 8'hA5;
    data_bit_num_i = DBITS_8;
    parity_en_i = 1'b0;
    stop_bit_num_i = 1'b0;
    data_valid_i = 1'b1;
    step();
    data_valid_i = 1'b0;
    base = tick_cnt;
    guard = 0;
    while (tick_cnt - base < 72 && guard < 500) begin
      step();
      guard++;
    end
    check("mid_busy", busy_o, 1);
    check("mid_data3_tx", tx_o, 0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_tx", tx_o, 1);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_ready", ready_o, 0);
    #2 reset_n = 1'b1;
    step();
    check("mid_rel_ready", ready_o, 1);
    send_frame("f8n1_55", 8'h55, DBITS_8, 1'b0, 1'b0, 1'b0, 12'b0010_1010_1010, 10, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
